rotl_pipe: RTL and testbench



---
 rtl/rotl_pkg.sv | 16 +
 rtl/rotl_stage.sv | 48 ++++
 rtl/rotl_pipe.sv | 82 ++++++++
 tb/tb_rotl_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rotl_pkg.sv
// Shared types and default sizing for the pipelined left-rotate shifter.
package rotl_pkg;

    localparam int ROTL_WIDTH = 8;
    localparam int ROTL_SHW   = 3;

    typedef logic [ROTL_WIDTH-1:0] rotl_word_t;
    typedef logic [ROTL_SHW-1:0]   rotl_amt_t;

    typedef struct packed {
        logic       v;
        rotl_word_t data;
        rotl_amt_t  amt;
    } rotl_stage_t;

endpackage

// File: rtl/rotl_stage.sv
// One pipeline register of rotl_pipe: conditionally rotates left by 2^K on capture.
module rotl_stage
    import rotl_pkg::*;
#(
    parameter int WIDTH = ROTL_WIDTH,
    parameter int SHW   = $clog2(WIDTH),
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_v,
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_amt,
    output logic             o_v,
    output logic [WIDTH-1:0] o_data,
    output logic [SHW-1:0]   o_amt
);

    localparam int SH = 1 << K;

    logic             r_v;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_amt;
    logic [WIDTH-1:0] w_rot;

    assign w_rot = {i_data[WIDTH-1-SH:0], i_data[WIDTH-1:WIDTH-SH]};

    // Payload only moves with a valid word so an idle stage keeps its last contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v    <= 1'b0;
            r_data <= '0;
            r_amt  <= '0;
        end else if (i_en) begin
            r_v <= i_v;
            if (i_v) begin
                r_data <= i_amt[K] ? w_rot : i_data;
                r_amt  <= i_amt;
            end
        end
    end

    assign o_v    = r_v;
    assign o_data = r_data;
    assign o_amt  = r_amt;

endmodule

// File: rtl/rotl_pipe.sv
// Pipelined left-rotate barrel shifter with valid/ready on both sides.
// Optional transfer counter port out_count when ROTL_PIPE_COUNT_EN is defined.
module rotl_pipe
    import rotl_pkg::*;
#(
    parameter int WIDTH = ROTL_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef ROTL_PIPE_COUNT_EN
    ,
    output logic [31:0]      out_count
`endif
);

    // Index 0 is the input port; index k+1 is the output of stage k.
    logic [SHW:0]            w_v;
    logic [SHW:0][WIDTH-1:0] w_data;
    logic [SHW:0][SHW-1:0]   w_amt;
    logic [SHW:0]            w_rdy;
    logic [SHW-1:0]          w_unused_amt;

    assign w_v[0]    = in_valid;
    assign w_data[0] = in_data;
    assign w_amt[0]  = in_amt;
    assign w_rdy[SHW] = out_ready;

    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : g_stage
            // A stage may capture if downstream takes its word or it is empty.
            assign w_rdy[k] = w_rdy[k+1] | ~w_v[k+1];

            rotl_stage #(
                .WIDTH (WIDTH),
                .SHW   (SHW),
                .K     (k)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .i_en   (w_rdy[k]),
                .i_v    (w_v[k]),
                .i_data (w_data[k]),
                .i_amt  (w_amt[k]),
                .o_v    (w_v[k+1]),
                .o_data (w_data[k+1]),
                .o_amt  (w_amt[k+1])
            );
        end
    endgenerate

    assign w_unused_amt = w_amt[SHW];

    assign in_ready  = w_rdy[0];
    assign out_valid = w_v[SHW];
    assign out_data  = w_data[SHW];

`ifdef ROTL_PIPE_COUNT_EN
    logic [31:0] r_count;
    logic        w_out_fire;

    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (w_out_fire)
            r_count <= r_count + 32'd1;
    end

    assign out_count = r_count;
`endif

endmodule

// File: tb/tb_rotl_pipe.sv
// Self-checking bench for rotl_pipe: directed and random words against a queue scoreboard.
module tb_rotl_pipe;
    import rotl_pkg::*;

    logic       clk, rst, in_valid, in_ready, out_valid, out_ready;
    rotl_word_t in_data, out_data;
    rotl_amt_t  in_amt;
`ifdef ROTL_PIPE_COUNT_EN
    logic [31:0] out_count;
`endif

    int          checks = 0;
    int          errors = 0;
    rotl_word_t  q[$];
    logic        prev_stall = 1'b0;
    rotl_word_t  prev_data;
    logic [31:0] n_xfer = '0;

    rotl_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef ROTL_PIPE_COUNT_EN
        ,
        .out_count (out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic rotl_word_t ref_rotl(input rotl_word_t d, input int a);
        logic [15:0] t;
        t = {d, d} << a;
        return t[15:8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check just after, update scoreboard at posedge.
    task automatic cycle(input logic iv, input rotl_word_t d, input rotl_amt_t a,
                         input logic ordy, output logic fired);
        logic exp_rdy, out_fire;
        in_valid = iv; in_data = d; in_amt = a; out_ready = ordy;
        #1;
        exp_rdy = ordy || (q.size() < 3);
        chk("in_ready", in_ready, exp_rdy);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
        end
        if (q.size() == 0) chk("empty_valid", out_valid, 0);
        else if (out_valid === 1'b1) chk("out_data", out_data, q[0]);
`ifdef ROTL_PIPE_COUNT_EN
        chk("out_count", out_count, n_xfer);
`endif
        fired      = iv && exp_rdy;
        out_fire   = (out_valid === 1'b1) && ordy;
        prev_stall = (out_valid === 1'b1) && !ordy;
        prev_data  = out_data;
        @(posedge clk);
        if (out_fire && q.size() > 0) begin
            void'(q.pop_front());
            n_xfer++;
        end
        if (fired) q.push_back(ref_rotl(d, int'(a)));
        @(negedge clk);
    endtask

    task automatic drain();
        logic f;
        for (int k = 0; k < 20 && q.size() != 0; k++) cycle(1'b0, '0, '0, 1'b1, f);
        chk("drain_empty", q.size(), 0);
        chk("drain_valid", out_valid, 0);
    endtask

    // Single word into an empty pipe: valid must appear exactly three edges later.
    task automatic one_word(input rotl_word_t d, input rotl_amt_t a, input rotl_word_t exp);
        logic f;
        cycle(1'b1, d, a, 1'b1, f);
        chk("lat_accept", f, 1);
        for (int k = 1; k <= 3; k++) begin
            if (k < 3) chk("lat_early", out_valid, 0);
            else begin
                chk("lat_valid", out_valid, 1);
                chk("lat_data", out_data, exp);
            end
            if (k < 3) cycle(1'b0, '0, '0, 1'b1, f);
        end
        drain();
    endtask

    initial begin
        logic       f;
        int         idx;
        logic [31:0] base;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef ROTL_PIPE_COUNT_EN
        chk("rst_count", out_count, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Basic rotates, identity and round trip
        one_word(8'hB4, 3'd3, 8'hA5);
        one_word(8'h01, 3'd7, 8'h80);
        one_word(8'h5A, 3'd0, 8'h5A);
        one_word(8'h0F, 3'd2, 8'h3C);

        // Exhaustive back-to-back sweep
        for (int i = 0; i < 2048; i++) begin
            cycle(1'b1, rotl_word_t'(i), rotl_amt_t'(i >> 8), 1'b1, f);
            chk("sweep_accept", f, 1);
            if (i >= 3) chk("sweep_tput", out_valid, 1);
        end
        drain();

        // Backpressure: 01..08 rotated by 1 with output stalled for 5 cycles
        idx  = 0;
        base = n_xfer;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, rotl_word_t'(idx + 1), 3'd1, 1'b0, f);
            if (f) idx++;
        end
        in_data = rotl_word_t'(idx + 1);
        #1;
        chk("bp_accepts", idx, 3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_hold", out_data, 8'h02);
        for (int k = 0; k < 30 && idx < 8; k++) begin
            cycle(1'b1, rotl_word_t'(idx + 1), 3'd1, 1'b1, f);
            if (f) idx++;
        end
        chk("bp_all_in", idx, 8);
        drain();
        chk("bp_outs", n_xfer - base, 8);

        // Random bubbles on both sides
        for (int k = 0; k < 400; k++)
            cycle(1'($urandom_range(0, 1)), rotl_word_t'($urandom), rotl_amt_t'($urandom),
                  1'($urandom_range(0, 1)), f);
        drain();

        // Asynchronous reset with three words in flight
        for (int k = 0; k < 3; k++) cycle(1'b1, rotl_word_t'(8'h11 * (k + 1)), 3'd5, 1'b0, f);
        chk("mid_full", q.size(), 3);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        q.delete();
        prev_stall = 1'b0;
        n_xfer = '0;
`ifdef ROTL_PIPE_COUNT_EN
        chk("mid_rst_count", out_count, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        one_word(8'hC3, 3'd4, 8'h3C);
        for (int k = 0; k < 5; k++) cycle(1'b0, '0, '0, 1'b1, f);

`ifdef ROTL_PIPE_COUNT_EN
        // Ten transfers, reset, then wrap from all-ones
        base = n_xfer;
        for (int k = 0; k < 10; k++) cycle(1'b1, rotl_word_t'(k), rotl_amt_t'(k), 1'b1, f);
        drain();
        chk("count_ten", out_count - base, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("count_rst", out_count, 0);
        n_xfer = '0;
        @(negedge clk);
        rst = 1'b0;
        force dut.r_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_count;
        n_xfer = 32'hFFFF_FFFF;
        chk("count_forced", out_count, 32'hFFFF_FFFF);
        @(negedge clk);
        one_word(8'h81, 3'd1, 8'h03);
        chk("count_wrap", out_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
